// File: rtl/eqm_pkg.sv
// Shared definitions for the equilibrium game control unit: state codes and
// the default game parameters.
package eqm_pkg;

  localparam int EQM_PONTOS_VITORIA = 10;
  localparam int EQM_TIMEOUT_CICLOS = 250_000_000;

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    CALIBRA     = 4'd1,
    PREPARA     = 4'd2,
    ESPERA_PREP = 4'd3,
    GERA        = 4'd4,
    JOGA        = 4'd5,
    AVALIA      = 4'd6,
    FIM         = 4'd7
  } estado_t;

endpackage

// File: rtl/contador_m.sv
// Modulo-M up counter with a synchronous clear and a count enable.
module contador_m #(
  parameter int M = 100,
  parameter int N = 7
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  output logic [N-1:0] q
);

  localparam logic [N-1:0] ULTIMO = N'(M - 1);
  localparam logic [N-1:0] UM     = N'(1);

  logic [N-1:0] q_r;

  // Count register: clear has priority over count, wraps at M-1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_r <= {N{1'b0}};
    end else if (zera) begin
      q_r <= {N{1'b0}};
    end else if (conta) begin
      if (q_r == ULTIMO) begin
        q_r <= {N{1'b0}};
      end else begin
        q_r <= q_r + UM;
      end
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/hexa7seg.sv
// Hex digit to active-low 7-segment pattern {g,f,e,d,c,b,a}; only built when
// EQM_UC_DB_ESTADO_EN is defined.
`ifdef EQM_UC_DB_ESTADO_EN
module hexa7seg (
  input  logic [3:0] valor,
  output logic [6:0] display
);

  // Segment lookup table.
  always_comb begin
    display = 7'b1111111;
    case (valor)
      4'h0:    display = 7'b1000000;
      4'h1:    display = 7'b1111001;
      4'h2:    display = 7'b0100100;
      4'h3:    display = 7'b0110000;
      4'h4:    display = 7'b0011001;
      4'h5:    display = 7'b0010010;
      4'h6:    display = 7'b0000010;
      4'h7:    display = 7'b1111000;
      4'h8:    display = 7'b0000000;
      4'h9:    display = 7'b0010000;
      4'hA:    display = 7'b0001000;
      4'hB:    display = 7'b0000011;
      4'hC:    display = 7'b1000110;
      4'hD:    display = 7'b0100001;
      4'hE:    display = 7'b0000110;
      4'hF:    display = 7'b0001110;
      default: display = 7'b1111111;
    endcase
  end

endmodule
`endif

// File: rtl/equilibrium_maxxing_uc.sv
// Control unit of the pendulum balance game: calibration, preparation, timed
// rounds and win/loss verdict. Define EQM_UC_DB_ESTADO_EN for the db_estado display.
module equilibrium_maxxing_uc
  import eqm_pkg::*;
#(
  parameter int PONTOS_VITORIA = EQM_PONTOS_VITORIA,
  parameter int TIMEOUT_CICLOS = EQM_TIMEOUT_CICLOS
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       fim_curso,
  input  logic       prep_done,
  input  logic       ganhou_ponto,
  input  logic       perdeu_ponto,
  input  logic [7:0] pontuacao,
  output logic       start_game,
  output logic       gerar_nova_jogada,
  output logic       conta_nivel,
  output logic       fade_trigger,
  output logic       calib_start,
  output logic       trava_servo,
  output logic       reset_prep_cnt,
  output logic       reset_nivel,
  output logic       reset_nivel_locked,
  output logic       pronto,
  output logic       vitoria,
  output logic       derrota
`ifdef EQM_UC_DB_ESTADO_EN
  ,
  output logic [6:0] db_estado
`endif
);

  localparam int TIMER_W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [TIMER_W-1:0] TIMER_ULTIMO = TIMER_W'(TIMEOUT_CICLOS - 1);
  localparam logic [7:0] PONTOS_ALVO = 8'(PONTOS_VITORIA);

  estado_t estado_r;
  estado_t proximo_s;

  // Set only after iniciar has been seen low, so a level held through reset
  // never counts as a press.
  logic iniciar_baixo_r;
  logic subida_s;

  logic perda_r;
  logic vitoria_r;
  logic derrota_r;
  logic start_game_r;
  logic conta_nivel_r;
  logic locked_r;

  logic               zera_timer_s;
  logic               conta_timer_s;
  logic [TIMER_W-1:0] timer_q_s;
  logic               timeout_s;
  logic               fim_rodada_s;
  logic               venceu_s;

  assign subida_s      = iniciar & iniciar_baixo_r;
  assign zera_timer_s  = (estado_r == GERA);
  assign conta_timer_s = (estado_r == JOGA);
  assign timeout_s     = (timer_q_s == TIMER_ULTIMO);
  assign fim_rodada_s  = ganhou_ponto | perdeu_ponto | timeout_s;
  assign venceu_s      = (pontuacao >= PONTOS_ALVO);

  contador_m #(
    .M(TIMEOUT_CICLOS),
    .N(TIMER_W)
  ) u_timer (
    .clock(clock),
    .reset(reset),
    .zera (zera_timer_s),
    .conta(conta_timer_s),
    .q    (timer_q_s)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_r <= INICIAL;
    end else begin
      estado_r <= proximo_s;
    end
  end

  // Next-state logic.
  always_comb begin
    proximo_s = estado_r;
    case (estado_r)
      INICIAL: begin
        if (subida_s) proximo_s = CALIBRA;
        else          proximo_s = INICIAL;
      end
      CALIBRA: begin
        if (fim_curso) proximo_s = PREPARA;
        else           proximo_s = CALIBRA;
      end
      PREPARA:     proximo_s = ESPERA_PREP;
      ESPERA_PREP: begin
        if (prep_done) proximo_s = GERA;
        else           proximo_s = ESPERA_PREP;
      end
      GERA:        proximo_s = JOGA;
      JOGA: begin
        if (fim_rodada_s) proximo_s = AVALIA;
        else              proximo_s = JOGA;
      end
      AVALIA: begin
        if (perda_r || venceu_s) proximo_s = FIM;
        else                     proximo_s = GERA;
      end
      FIM: begin
        if (subida_s) proximo_s = INICIAL;
        else          proximo_s = FIM;
      end
      default:     proximo_s = INICIAL;
    endcase
  end

  // Result flags and the one-cycle handshakes that depend on inputs are
  // registered so no input reaches an output combinationally.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      iniciar_baixo_r <= 1'b0;
      perda_r         <= 1'b0;
      vitoria_r       <= 1'b0;
      derrota_r       <= 1'b0;
      start_game_r    <= 1'b0;
      conta_nivel_r   <= 1'b0;
      locked_r        <= 1'b0;
    end else begin
      iniciar_baixo_r <= ~iniciar;
      start_game_r    <= (estado_r == ESPERA_PREP) && prep_done;
      conta_nivel_r   <= (estado_r == AVALIA) && !perda_r && !venceu_s;

      if (estado_r == GERA) begin
        perda_r <= 1'b0;
      end else if ((estado_r == JOGA) && fim_rodada_s) begin
        perda_r <= perdeu_ponto | timeout_s;
      end else begin
        perda_r <= perda_r;
      end

      if (proximo_s == INICIAL) begin
        vitoria_r <= 1'b0;
        derrota_r <= 1'b0;
      end else if (estado_r == AVALIA) begin
        derrota_r <= perda_r;
        vitoria_r <= !perda_r && venceu_s;
      end else begin
        vitoria_r <= vitoria_r;
        derrota_r <= derrota_r;
      end

      if (proximo_s == INICIAL) begin
        locked_r <= 1'b0;
      end else if ((estado_r == ESPERA_PREP) && prep_done) begin
        locked_r <= 1'b1;
      end else begin
        locked_r <= locked_r;
      end
    end
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    reset_nivel       = 1'b0;
    calib_start       = 1'b0;
    reset_prep_cnt    = 1'b0;
    trava_servo       = 1'b0;
    gerar_nova_jogada = 1'b0;
    fade_trigger      = 1'b0;
    pronto            = 1'b0;
    case (estado_r)
      INICIAL:     reset_nivel = 1'b1;
      CALIBRA:     calib_start = 1'b1;
      PREPARA:     reset_prep_cnt = 1'b1;
      ESPERA_PREP: trava_servo = 1'b1;
      GERA: begin
        gerar_nova_jogada = 1'b1;
        fade_trigger      = 1'b1;
      end
      JOGA, AVALIA: begin
        pronto = 1'b0;
      end
      FIM:         pronto = 1'b1;
      default:     reset_nivel = 1'b1;
    endcase
  end

  assign start_game         = start_game_r;
  assign conta_nivel        = conta_nivel_r;
  assign reset_nivel_locked = locked_r;
  assign vitoria            = vitoria_r;
  assign derrota            = derrota_r;

`ifdef EQM_UC_DB_ESTADO_EN
  hexa7seg u_hexa7seg (
    .valor  (4'(estado_r)),
    .display(db_estado)
  );
`endif

endmodule

// File: tb/tb_equilibrium_maxxing_uc.sv
// Scoreboard bench for equilibrium_maxxing_uc: win, loss, simultaneous result,
// timeout and mid-round reset scenarios.
module tb_equilibrium_maxxing_uc;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic       fim_curso = 1'b0;
  logic       prep_done = 1'b0;
  logic       ganhou_ponto = 1'b0;
  logic       perdeu_ponto = 1'b0;
  logic [7:0] pontuacao = 8'd0;
  logic start_game, gerar_nova_jogada, conta_nivel, fade_trigger, calib_start;
  logic trava_servo, reset_prep_cnt, reset_nivel, reset_nivel_locked;
  logic pronto, vitoria, derrota;
`ifdef EQM_UC_DB_ESTADO_EN
  logic [6:0] db_estado;
`endif

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  // Event vector: {pronto, vitoria, derrota, conta_nivel, gerar, fade, start_game, reset_prep}
  localparam logic [7:0] EV_PREP  = 8'b0000_0001;
  localparam logic [7:0] EV_START = 8'b0000_1110;
  localparam logic [7:0] EV_CONTA = 8'b0001_1100;
  localparam logic [7:0] EV_WIN   = 8'b1100_0000;
  localparam logic [7:0] EV_LOSS  = 8'b1010_0000;
  localparam logic [11:0] OUT_RESET = 12'h010;

  always #5 clock = ~clock;

  equilibrium_maxxing_uc #(
    .PONTOS_VITORIA(10),
    .TIMEOUT_CICLOS(100)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .fim_curso(fim_curso),
    .prep_done(prep_done), .ganhou_ponto(ganhou_ponto), .perdeu_ponto(perdeu_ponto),
    .pontuacao(pontuacao), .start_game(start_game), .gerar_nova_jogada(gerar_nova_jogada),
    .conta_nivel(conta_nivel), .fade_trigger(fade_trigger), .calib_start(calib_start),
    .trava_servo(trava_servo), .reset_prep_cnt(reset_prep_cnt), .reset_nivel(reset_nivel),
    .reset_nivel_locked(reset_nivel_locked), .pronto(pronto), .vitoria(vitoria),
    .derrota(derrota)
`ifdef EQM_UC_DB_ESTADO_EN
    , .db_estado(db_estado)
`endif
  );

  function automatic logic [11:0] all_outputs();
    return {start_game, gerar_nova_jogada, conta_nivel, fade_trigger, calib_start,
            trava_servo, reset_prep_cnt, reset_nivel, reset_nivel_locked,
            pronto, vitoria, derrota};
  endfunction

  task automatic check(input string nome, input logic [31:0] got, input logic [31:0] esp);
    tests++;
    if (got !== esp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nome, got, got, esp, esp);
    end
  endtask

  // Monitor: any handshake pulse or the rise of pronto is one event to score.
  initial begin
    logic [7:0] ev;
    logic [7:0] esp;
    logic       pronto_ant;
    pronto_ant = 1'b0;
    forever begin
      @(negedge clock);
      ev = {pronto, vitoria, derrota, conta_nivel, gerar_nova_jogada,
            fade_trigger, start_game, reset_prep_cnt};
      if ((|ev[4:0]) || (pronto && !pronto_ant)) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event: got %b expected none", ev);
        end else begin
          esp = exp_q.pop_front();
          if (ev !== esp) begin
            fails++;
            $display("FAIL event: got %b expected %b", ev, esp);
          end
        end
      end
      pronto_ant = pronto;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press_iniciar();
    iniciar = 1'b0;
    tick(1);
    iniciar = 1'b1;
    tick(1);
    iniciar = 1'b0;
  endtask

  task automatic wait_gerar();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (gerar_nova_jogada) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_gerar", 32'(ok), 32'd1);
  endtask

  task automatic wait_pronto();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (pronto) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_pronto", 32'(ok), 32'd1);
  endtask

  // From INICIAL through calibration and preparation into the first GERA.
  task automatic begin_game();
    logic ok;
    press_iniciar();
    tick(19);
    @(negedge clock);
    check("calib_start", 32'(calib_start), 32'd1);
    check("reset_nivel_off", 32'(reset_nivel), 32'd0);
    tick(1);
    exp_q.push_back(EV_PREP);
    fim_curso = 1'b1;
    tick(1);
    fim_curso = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (trava_servo) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_trava_servo", 32'(ok), 32'd1);
    check("locked_before_start", 32'(reset_nivel_locked), 32'd0);
    tick(1);
    exp_q.push_back(EV_START);
    prep_done = 1'b1;
    tick(1);
    prep_done = 1'b0;
  endtask

  task automatic play_round(input logic g, input logic p, input logic [7:0] pts);
    wait_gerar();
    check("locked_in_game", 32'(reset_nivel_locked), 32'd1);
    tick(3);
`ifdef EQM_UC_DB_ESTADO_EN
    check("db_estado_joga", 32'(db_estado), 32'(7'b0010010));
`endif
    ganhou_ponto = g;
    perdeu_ponto = p;
    pontuacao    = pts;
    tick(1);
    ganhou_ponto = 1'b0;
    perdeu_ponto = 1'b0;
  endtask

  task automatic back_to_inicial();
    press_iniciar();
    @(negedge clock);
    check("inicial_outputs", 32'(all_outputs()), 32'(OUT_RESET));
    pontuacao = 8'd0;
  endtask

  initial begin
    int lat;
    #1;
    check("reset_outputs", 32'(all_outputs()), 32'(OUT_RESET));
    tick(3);
    reset = 1'b1;
    tick(3);
    @(negedge clock);
    check("idle_outputs", 32'(all_outputs()), 32'(OUT_RESET));

    // Win: ten scored rounds, nine level steps.
    begin_game();
    for (int r = 1; r <= 10; r++) begin
      if (r < 10) exp_q.push_back(EV_CONTA);
      else        exp_q.push_back(EV_WIN);
      play_round(1'b1, 1'b0, 8'(r));
    end
    wait_pronto();
    tick(3);
    @(negedge clock);
    check("win_vitoria", 32'(vitoria), 32'd1);
    check("win_derrota", 32'(derrota), 32'd0);
    check("win_pronto", 32'(pronto), 32'd1);
    back_to_inicial();

    // Loss in the third round.
    begin_game();
    exp_q.push_back(EV_CONTA);
    play_round(1'b1, 1'b0, 8'd1);
    exp_q.push_back(EV_CONTA);
    play_round(1'b1, 1'b0, 8'd2);
    exp_q.push_back(EV_LOSS);
    play_round(1'b0, 1'b1, 8'd2);
    wait_pronto();
    check("loss_derrota", 32'(derrota), 32'd1);
    check("loss_vitoria", 32'(vitoria), 32'd0);
    back_to_inicial();

    // Simultaneous win and loss counts as a loss.
    begin_game();
    exp_q.push_back(EV_LOSS);
    play_round(1'b1, 1'b1, 8'd1);
    wait_pronto();
    check("simul_derrota", 32'(derrota), 32'd1);
    check("simul_vitoria", 32'(vitoria), 32'd0);
    back_to_inicial();

    // Timeout: GERA, 100 JOGA cycles, AVALIA, then FIM 102 cycles after GERA.
    begin_game();
    exp_q.push_back(EV_LOSS);
    wait_gerar();
    lat = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clock);
      if (pronto) begin
        lat = i;
        break;
      end
    end
    check("timeout_latency", 32'(lat), 32'd102);
    check("timeout_derrota", 32'(derrota), 32'd1);
    back_to_inicial();

    // Reset in the middle of a round with iniciar held high.
    begin_game();
    wait_gerar();
    tick(3);
    iniciar = 1'b1;
    reset   = 1'b0;
    #1;
    check("midreset_outputs", 32'(all_outputs()), 32'(OUT_RESET));
`ifdef EQM_UC_DB_ESTADO_EN
    check("db_estado_inicial", 32'(db_estado), 32'(7'b1000000));
`endif
    tick(2);
    reset = 1'b1;
    tick(30);
    @(negedge clock);
    check("no_restart_calib", 32'(calib_start), 32'd0);
    check("no_restart_outputs", 32'(all_outputs()), 32'(OUT_RESET));
    iniciar = 1'b0;
    tick(5);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

endmodule
